neg_acc: RTL and testbench



---
 rtl/neg_acc.sv | 89 ++++++++
 tb/tb_neg_acc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/neg_acc.sv
// Streaming signed accumulator: sums every CNT accepted samples into one DOUT-bit frame sum.
// Define NEG_ACC_SAT_EN to saturate each add instead of wrapping modulo 2^DOUT.
module neg_acc #(
  parameter int unsigned DIN  = 16,
  parameter int unsigned DOUT = 24,
  parameter int unsigned CNT  = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            din_ready,
  input  logic            din_valid,
  input  logic [DIN-1:0]  din_data,
  input  logic            dout_ready,
  output logic            dout_valid,
  output logic [DOUT-1:0] dout_data
);

  localparam int unsigned CW = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CNT - 1);
`ifdef NEG_ACC_SAT_EN
  localparam int unsigned AW = DOUT + 1;
  localparam logic [DOUT-1:0] SMAX = {1'b0, {(DOUT-1){1'b1}}};
  localparam logic [DOUT-1:0] SMIN = {1'b1, {(DOUT-1){1'b0}}};
`else
  localparam int unsigned AW = DOUT;
`endif

  logic [DOUT-1:0]      acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DOUT-1:0]      dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 is_last, accept;
  logic signed [AW-1:0] samp_w, base_w, sum_w;
  logic [DOUT-1:0]      sum;

  assign is_last    = (cnt_q == LAST);
  assign din_ready  = !is_last || !vld_q || dout_ready;
  assign accept     = din_valid && din_ready;
  assign dout_valid = vld_q;
  assign dout_data  = dout_q;

  // Frame sum: first sample of a frame starts from zero rather than the stale acc.
  always_comb begin
    samp_w = AW'($signed(din_data));
    base_w = (cnt_q == '0) ? '0 : AW'($signed(acc_q));
    sum_w  = base_w + samp_w;
`ifdef NEG_ACC_SAT_EN
    if (sum_w[AW-1] != sum_w[AW-2]) begin
      sum = sum_w[AW-1] ? SMIN : SMAX;
    end else begin
      sum = sum_w[DOUT-1:0];
    end
`else
    sum = sum_w[DOUT-1:0];
`endif
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    vld_d  = vld_q && !dout_ready;
    if (accept) begin
      if (is_last) begin
        dout_d = sum;
        vld_d  = 1'b1;
        cnt_d  = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: tb/tb_neg_acc.sv
// Directed bench for neg_acc: three instances cover CNT=4 (12/8-bit sums) and CNT=1.
module tb_neg_acc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: DIN=8, DOUT=12, CNT=4
  logic        a_rdy, a_v, a_r, a_ov;
  logic [7:0]  a_d;
  logic [11:0] a_od;
  // Instance B: DIN=8, DOUT=8, CNT=4
  logic        b_rdy, b_v, b_r, b_ov;
  logic [7:0]  b_d;
  logic [7:0]  b_od;
  // Instance C: DIN=8, DOUT=12, CNT=1
  logic        c_rdy, c_v, c_r, c_ov;
  logic [7:0]  c_d;
  logic [11:0] c_od;

  neg_acc #(.DIN(8), .DOUT(12), .CNT(4)) u_a (
    .clk(clk), .rst(rst), .din_ready(a_rdy), .din_valid(a_v), .din_data(a_d),
    .dout_ready(a_r), .dout_valid(a_ov), .dout_data(a_od));
  neg_acc #(.DIN(8), .DOUT(8), .CNT(4)) u_b (
    .clk(clk), .rst(rst), .din_ready(b_rdy), .din_valid(b_v), .din_data(b_d),
    .dout_ready(b_r), .dout_valid(b_ov), .dout_data(b_od));
  neg_acc #(.DIN(8), .DOUT(12), .CNT(1)) u_c (
    .clk(clk), .rst(rst), .din_ready(c_rdy), .din_valid(c_v), .din_data(c_d),
    .dout_ready(c_r), .dout_valid(c_ov), .dout_data(c_od));

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        erdy;
    logic        evld;
    logic [11:0] edat;
  } vec_t;

  localparam int NV = 29;
  vec_t tv [NV];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic v, logic [7:0] d, logic r,
                              logic erdy, logic evld, logic [11:0] edat);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.erdy = erdy; t.evld = evld; t.edat = edat;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive A at the falling edge, then check outputs before the next rising edge.
  task automatic step_a(input string tag, input logic v, input logic [7:0] d, input logic r,
                        input logic erdy, input logic evld, input logic [11:0] edat);
    @(negedge clk);
    a_v = v; a_d = d; a_r = r;
    #1;
    chk({tag, " a_rdy"}, 32'(a_rdy), 32'(erdy));
    chk({tag, " a_vld"}, 32'(a_ov), 32'(evld));
    chk({tag, " a_dat"}, 32'(a_od), 32'(edat));
  endtask

  initial begin
    rst = 1'b0;
    a_v = 1'b0; a_d = '0; a_r = 1'b1;
    b_v = 1'b0; b_d = '0; b_r = 1'b1;
    c_v = 1'b0; c_d = '0; c_r = 1'b1;

    // 1,2,3,4 -> 10
    tv[0]  = mk(1, 8'd1,  1, 1, 0, 12'h000);
    tv[1]  = mk(1, 8'd2,  1, 1, 0, 12'h000);
    tv[2]  = mk(1, 8'd3,  1, 1, 0, 12'h000);
    tv[3]  = mk(1, 8'd4,  1, 1, 0, 12'h000);
    tv[4]  = mk(0, 8'd0,  1, 1, 1, 12'd10);
    tv[5]  = mk(0, 8'd0,  1, 1, 0, 12'd10);
    // -128 x4 -> 0xE00, then 127 x4 -> 0x1FC with no gap
    tv[6]  = mk(1, 8'h80, 1, 1, 0, 12'd10);
    tv[7]  = mk(1, 8'h80, 1, 1, 0, 12'd10);
    tv[8]  = mk(1, 8'h80, 1, 1, 0, 12'd10);
    tv[9]  = mk(1, 8'h80, 1, 1, 0, 12'd10);
    tv[10] = mk(1, 8'h7F, 1, 1, 1, 12'hE00);
    tv[11] = mk(1, 8'h7F, 1, 1, 0, 12'hE00);
    tv[12] = mk(1, 8'h7F, 1, 1, 0, 12'hE00);
    tv[13] = mk(1, 8'h7F, 1, 1, 0, 12'hE00);
    tv[14] = mk(0, 8'd0,  1, 1, 1, 12'h1FC);
    tv[15] = mk(0, 8'd0,  1, 1, 0, 12'h1FC);
    // backpressure: 1 x4 then 2 x4, last sample stalls until dout_ready
    tv[16] = mk(1, 8'd1,  0, 1, 0, 12'h1FC);
    tv[17] = mk(1, 8'd1,  0, 1, 0, 12'h1FC);
    tv[18] = mk(1, 8'd1,  0, 1, 0, 12'h1FC);
    tv[19] = mk(1, 8'd1,  0, 1, 0, 12'h1FC);
    tv[20] = mk(1, 8'd2,  0, 1, 1, 12'd4);
    tv[21] = mk(1, 8'd2,  0, 1, 1, 12'd4);
    tv[22] = mk(1, 8'd2,  0, 1, 1, 12'd4);
    tv[23] = mk(1, 8'd2,  0, 0, 1, 12'd4);
    tv[24] = mk(1, 8'd2,  0, 0, 1, 12'd4);
    tv[25] = mk(1, 8'd2,  1, 1, 1, 12'd4);
    tv[26] = mk(0, 8'd0,  0, 1, 1, 12'd8);
    tv[27] = mk(0, 8'd0,  1, 1, 1, 12'd8);
    tv[28] = mk(0, 8'd0,  0, 1, 0, 12'd8);

    // reset state
    #12;
    chk("rst a_vld", 32'(a_ov), 32'd0);
    chk("rst a_dat", 32'(a_od), 32'd0);
    chk("rst a_rdy", 32'(a_rdy), 32'd1);
    chk("rst c_vld", 32'(c_ov), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step_a($sformatf("v%0d", i), tv[i].v, tv[i].d, tv[i].r,
             tv[i].erdy, tv[i].evld, tv[i].edat);
    end

    // B: 100 x4 into an 8-bit sum
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_v = 1'b1; b_d = 8'd100;
    end
    @(negedge clk);
    b_v = 1'b0;
    #1;
    chk("b_vld", 32'(b_ov), 32'd1);
`ifdef NEG_ACC_SAT_EN
    chk("b_dat", 32'(b_od), 32'h7F);
`else
    chk("b_dat", 32'(b_od), 32'h90);
`endif

    // C: CNT=1, -3 then 7 back to back
    @(negedge clk);
    c_v = 1'b1; c_d = 8'hFD;
    #1;
    chk("c0 rdy", 32'(c_rdy), 32'd1);
    chk("c0 vld", 32'(c_ov), 32'd0);
    @(negedge clk);
    c_d = 8'd7;
    #1;
    chk("c1 rdy", 32'(c_rdy), 32'd1);
    chk("c1 vld", 32'(c_ov), 32'd1);
    chk("c1 dat", 32'(c_od), 32'hFFD);
    @(negedge clk);
    c_v = 1'b0;
    #1;
    chk("c2 rdy", 32'(c_rdy), 32'd1);
    chk("c2 vld", 32'(c_ov), 32'd1);
    chk("c2 dat", 32'(c_od), 32'd7);
    @(negedge clk);
    #1;
    chk("c3 vld", 32'(c_ov), 32'd0);

    // A: partial frame 5,5 discarded by a one-cycle mid-frame reset
    step_a("r0", 1, 8'd5, 1, 1, 0, 12'd8);
    step_a("r1", 1, 8'd5, 1, 1, 0, 12'd8);
    @(negedge clk);
    a_v = 1'b0; rst = 1'b0;
    #1;
    chk("rstmid a_vld", 32'(a_ov), 32'd0);
    chk("rstmid a_dat", 32'(a_od), 32'd0);
    chk("rstmid a_rdy", 32'(a_rdy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step_a("p0", 1, 8'd1, 1, 1, 0, 12'd0);
    step_a("p1", 1, 8'd1, 1, 1, 0, 12'd0);
    step_a("p2", 1, 8'd1, 1, 1, 0, 12'd0);
    step_a("p3", 1, 8'd1, 1, 1, 0, 12'd0);
    step_a("p4", 0, 8'd0, 1, 1, 1, 12'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
